// File: rtl/fir_i2s_tx_if.sv
// Sample input and I2S output bundle for the FIR output stage.
// The master drives samples; the slave is the serialiser.
interface fir_i2s_tx_if;
    logic [23:0] audio_in;
    logic        sample_valid;
    logic        i2s_bclk;
    logic        i2s_lrclk;
    logic        i2s_sdata;
    logic        frame_start;

    modport master (
        output audio_in,
        output sample_valid,
        input  i2s_bclk,
        input  i2s_lrclk,
        input  i2s_sdata,
        input  frame_start
    );

    modport slave (
        input  audio_in,
        input  sample_valid,
        output i2s_bclk,
        output i2s_lrclk,
        output i2s_sdata,
        output frame_start
    );
endinterface

// File: rtl/fir_i2s_tx.sv
// FIR output stage: scale/saturate to 16 bits, hold one sample,
// serialise as mono I2S with underrun/overflow sticky flags.
module fir_i2s_tx #(
    parameter int CLK_DIV    = 4,
    parameter int GAIN_SHIFT = 7,
    parameter int SLOT_BITS  = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    fir_i2s_tx_if.slave bus,
    input  logic        clear_status,
    output logic        underrun,
    output logic        overflow
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int BW = $clog2(2 * SLOT_BITS);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_BITS - 1);
    localparam logic [BW-1:0] SLOT     = BW'(SLOT_BITS);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state;
    logic [DW-1:0]  div_cnt;
    logic [BW-1:0]  bit_cnt;
    logic [15:0]    holding;
    logic [15:0]    word;
    logic           full;
    logic           load_pend;
    logic           bclk;
    logic           lrclk;
    logic           sdata;
    logic           fstart;

    logic signed [23:0] scaled;
    logic [15:0]        sat;
    logic               wrap;
    logic               fall;
    logic               load;
    logic [BW-1:0]      nxt_bit;
    logic [BW-1:0]      p;
    logic [BW-1:0]      q;
    logic [3:0]         idx;
    logic               nxt_sd;

    always_comb begin
        scaled = $signed(bus.audio_in) >>> GAIN_SHIFT;
        if (scaled > 24'sd32767)
            sat = 16'h7FFF;
        else if (scaled < -24'sd32768)
            sat = 16'h8000;
        else
            sat = scaled[15:0];
    end

    // The first RUN cycle is a bit_cnt=0 load of the triggering sample
    always_comb begin
        wrap    = (div_cnt == DIV_LAST);
        fall    = (state == RUN) && !load_pend && wrap && bclk;
        nxt_bit = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
        load    = (state == RUN) &&
                  (load_pend || (fall && nxt_bit == '0));
        p       = (nxt_bit == '0) ? BIT_LAST : nxt_bit - 1'b1;
        q       = (p >= SLOT) ? p - SLOT : p;
        idx     = 4'd15 - q[3:0];
        nxt_sd  = (q < BW'(16)) ? word[idx] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            holding   <= '0;
            word      <= '0;
            full      <= 1'b0;
            load_pend <= 1'b0;
            bclk      <= 1'b0;
            lrclk     <= 1'b0;
            sdata     <= 1'b0;
            fstart    <= 1'b0;
            underrun  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            fstart <= load;
            if (bus.sample_valid) begin
                holding <= sat;
                full    <= 1'b1;
            end else if (load) begin
                full <= 1'b0;
            end
            if (load && full)
                word <= holding;
            if (bus.sample_valid && full && !load)
                overflow <= 1'b1;
            else if (clear_status)
                overflow <= 1'b0;
            if (load && !full)
                underrun <= 1'b1;
            else if (clear_status)
                underrun <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.sample_valid) begin
                        state     <= RUN;
                        load_pend <= 1'b1;
                    end
                end
                RUN: begin
                    if (load_pend) begin
                        load_pend <= 1'b0;
                    end else begin
                        div_cnt <= wrap ? '0 : div_cnt + 1'b1;
                        if (wrap)
                            bclk <= !bclk;
                        if (fall) begin
                            bit_cnt <= nxt_bit;
                            lrclk   <= (nxt_bit >= SLOT);
                            sdata   <= nxt_sd;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.i2s_bclk    = bclk;
    assign bus.i2s_lrclk   = lrclk;
    assign bus.i2s_sdata   = sdata;
    assign bus.frame_start = fstart;
endmodule
